// File: rtl/eth_baser_pkg.sv
// Shared 10GBASE-R definitions: sync headers, block types, XGMII characters,
// 7-bit control codes and the receive frame-state enum.
package eth_baser_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  localparam logic [7:0] BT_CTRL  = 8'h1E;
  localparam logic [7:0] BT_S0    = 8'h78;
  localparam logic [7:0] BT_C_S4  = 8'h33;
  localparam logic [7:0] BT_OS_S4 = 8'h66;
  localparam logic [7:0] BT_OS_OS = 8'h55;
  localparam logic [7:0] BT_OS_C  = 8'h4B;
  localparam logic [7:0] BT_T0    = 8'h87;
  localparam logic [7:0] BT_T1    = 8'h99;
  localparam logic [7:0] BT_T2    = 8'hAA;
  localparam logic [7:0] BT_T3    = 8'hB4;
  localparam logic [7:0] BT_T4    = 8'hCC;
  localparam logic [7:0] BT_T5    = 8'hD2;
  localparam logic [7:0] BT_T6    = 8'hE1;
  localparam logic [7:0] BT_T7    = 8'hFF;

  localparam logic [7:0] XG_IDLE  = 8'h07;
  localparam logic [7:0] XG_START = 8'hFB;
  localparam logic [7:0] XG_TERM  = 8'hFD;
  localparam logic [7:0] XG_ERROR = 8'hFE;
  localparam logic [7:0] XG_SEQ   = 8'h9C;

  localparam logic [6:0] CC_IDLE  = 7'h00;
  localparam logic [6:0] CC_ERROR = 7'h1E;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_IN_FRAME = 1'b1
  } frame_state_t;

  // Returns {is_terminate, terminate_lane} for a control block type.
  function automatic logic [3:0] term_lane(input logic [7:0] block_type);
    logic [3:0] res;
    case (block_type)
      BT_T0:   res = 4'b1_000;
      BT_T1:   res = 4'b1_001;
      BT_T2:   res = 4'b1_010;
      BT_T3:   res = 4'b1_011;
      BT_T4:   res = 4'b1_100;
      BT_T5:   res = 4'b1_101;
      BT_T6:   res = 4'b1_110;
      BT_T7:   res = 4'b1_111;
      default: res = 4'b0_000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/xgmii_baser_ctrl_lane_dec.sv
// Single-lane 7-bit 64b/66b control code to XGMII octet decoder.
module xgmii_baser_ctrl_lane_dec
  import eth_baser_pkg::*;
(
  input  logic [6:0] i_code,
  output logic [7:0] o_octet,
  output logic       o_illegal
);

  always_comb begin
    o_octet   = XG_ERROR;
    o_illegal = 1'b1;
    case (i_code)
      CC_IDLE: begin
        o_octet   = XG_IDLE;
        o_illegal = 1'b0;
      end
      CC_ERROR: begin
        o_octet   = XG_ERROR;
        o_illegal = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/xgmii_baser_dec_64.sv
// 64b/66b block to 64-bit XGMII decoder, one block per clock, 1-cycle latency.
// Define XGMII_BASER_DEC_SEQ_CHECK_EN to enable frame-ordering checks.
module xgmii_baser_dec_64
  import eth_baser_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int HDR_WIDTH  = 2
)
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] encoded_rx_data,
  input  logic [HDR_WIDTH-1:0]  encoded_rx_hdr,
  output logic [DATA_WIDTH-1:0] xgmii_rxd,
  output logic [CTRL_WIDTH-1:0] xgmii_rxc,
  output logic                  rx_bad_block,
  output logic                  rx_sequence_error
);

  localparam logic [63:0] ERR_BLOCK  = {8{XG_ERROR}};
  localparam logic [63:0] IDLE_BLOCK = {8{XG_IDLE}};

  logic [7:0]  w_block_type;
  logic [63:0] w_payload;
  logic [7:0]  w_lane_octet [8];
  logic [7:0]  w_lane_illegal;
  logic [63:0] w_ctrl_rxd;
  logic [3:0]  w_term;
  logic [63:0] w_rxd;
  logic [7:0]  w_rxc;
  logic        w_bad;
  logic        w_seq_err;

  logic [DATA_WIDTH-1:0] r_rxd;
  logic [CTRL_WIDTH-1:0] r_rxc;
  logic                  r_bad;
  logic                  r_seq_err;

  assign w_block_type = encoded_rx_data[7:0];
  // Payload octet k of a terminate block sits in byte k+1 of the block.
  assign w_payload    = {8'h00, encoded_rx_data[63:8]};
  assign w_term       = term_lane(w_block_type);

  // Every block type places lane i's 7-bit code at bit 8+7*i.
  for (genvar g = 0; g < 8; g++) begin : g_lane
    xgmii_baser_ctrl_lane_dec u_lane_dec (
      .i_code    (encoded_rx_data[8+7*g +: 7]),
      .o_octet   (w_lane_octet[g]),
      .o_illegal (w_lane_illegal[g])
    );
    assign w_ctrl_rxd[8*g +: 8] = w_lane_octet[g];
  end

  always_comb begin
    w_rxd = ERR_BLOCK;
    w_rxc = 8'hFF;
    w_bad = 1'b0;
    if (encoded_rx_hdr == SYNC_DATA) begin
      w_rxd = encoded_rx_data;
      w_rxc = 8'h00;
    end else if (encoded_rx_hdr == SYNC_CTRL) begin
      case (w_block_type)
        BT_CTRL: begin
          if (|w_lane_illegal) begin
            w_bad = 1'b1;
          end else begin
            w_rxd = w_ctrl_rxd;
            w_rxc = 8'hFF;
          end
        end
        BT_S0: begin
          w_rxd = {encoded_rx_data[63:8], XG_START};
          w_rxc = 8'h01;
        end
        BT_C_S4: begin
          if (|w_lane_illegal[3:0]) begin
            w_bad = 1'b1;
          end else begin
            w_rxd = {encoded_rx_data[63:40], XG_START, w_ctrl_rxd[31:0]};
            w_rxc = 8'h1F;
          end
        end
        BT_OS_S4: begin
          w_rxd = {encoded_rx_data[63:40], XG_START, encoded_rx_data[31:8], XG_SEQ};
          w_rxc = 8'h11;
        end
        BT_OS_OS: begin
          w_rxd = {encoded_rx_data[63:40], XG_SEQ, encoded_rx_data[31:8], XG_SEQ};
          w_rxc = 8'h11;
        end
        BT_OS_C: begin
          if (|w_lane_illegal[7:4]) begin
            w_bad = 1'b1;
          end else begin
            w_rxd = {w_ctrl_rxd[63:32], encoded_rx_data[31:8], XG_SEQ};
            w_rxc = 8'hF1;
          end
        end
        default: begin
          if (w_term[3]) begin
            for (int k = 0; k < 8; k++) begin
              if (3'(k) < w_term[2:0]) begin
                w_rxd[8*k +: 8] = w_payload[8*k +: 8];
                w_rxc[k]        = 1'b0;
              end else if (3'(k) == w_term[2:0]) begin
                w_rxd[8*k +: 8] = XG_TERM;
                w_rxc[k]        = 1'b1;
              end else begin
                w_rxd[8*k +: 8] = XG_IDLE;
                w_rxc[k]        = 1'b1;
              end
            end
          end else begin
            w_bad = 1'b1;
          end
        end
      endcase
    end else begin
      w_bad = 1'b1;
    end
  end

`ifdef XGMII_BASER_DEC_SEQ_CHECK_EN
  frame_state_t r_state;
  frame_state_t w_state_nxt;
  logic         w_is_data;
  logic         w_is_start;
  logic         w_is_term;

  assign w_is_data  = (encoded_rx_hdr == SYNC_DATA);
  assign w_is_start = (encoded_rx_hdr == SYNC_CTRL) &&
                      ((w_block_type == BT_S0) || (w_block_type == BT_C_S4) ||
                       (w_block_type == BT_OS_S4));
  assign w_is_term  = (encoded_rx_hdr == SYNC_CTRL) && w_term[3];

  // Bad blocks win; what remains is all-control or ordered-set blocks.
  always_comb begin
    w_seq_err   = 1'b0;
    w_state_nxt = r_state;
    if (w_bad) begin
      w_state_nxt = ST_IDLE;
    end else if (w_is_data) begin
      w_seq_err = (r_state == ST_IDLE);
    end else if (w_is_start) begin
      w_seq_err   = (r_state == ST_IN_FRAME);
      w_state_nxt = ST_IN_FRAME;
    end else if (w_is_term) begin
      w_seq_err   = (r_state == ST_IDLE);
      w_state_nxt = ST_IDLE;
    end else begin
      w_seq_err   = (r_state == ST_IN_FRAME);
      w_state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end
`else
  assign w_seq_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rxd     <= IDLE_BLOCK;
      r_rxc     <= 8'hFF;
      r_bad     <= 1'b0;
      r_seq_err <= 1'b0;
    end else begin
      r_rxd     <= w_seq_err ? ERR_BLOCK : w_rxd;
      r_rxc     <= w_seq_err ? 8'hFF : w_rxc;
      r_bad     <= w_bad;
      r_seq_err <= w_seq_err;
    end
  end

  assign xgmii_rxd         = r_rxd;
  assign xgmii_rxc         = r_rxc;
  assign rx_bad_block      = r_bad;
  assign rx_sequence_error = r_seq_err;

endmodule

// File: tb/tb_xgmii_baser_dec_64.sv
// Table-driven bench for xgmii_baser_dec_64 with an expected-result queue.
module tb_xgmii_baser_dec_64;

`ifdef XGMII_BASER_DEC_SEQ_CHECK_EN
  localparam bit SEQ_EN = 1'b1;
`else
  localparam bit SEQ_EN = 1'b0;
`endif

  localparam logic [63:0] ERR = {8{8'hFE}};
  localparam logic [63:0] IDL = {8{8'h07}};

  typedef struct {
    string       name;
    logic [1:0]  hdr;
    logic [63:0] data;
    logic [63:0] rxd;
    logic [7:0]  rxc;
    logic        bad;
    logic        seq;  // block is a sequence error when ordering checks are built in
  } vec_t;

  logic        clk;
  logic        rst;
  logic [63:0] encoded_rx_data;
  logic [1:0]  encoded_rx_hdr;
  logic [63:0] xgmii_rxd;
  logic [7:0]  xgmii_rxc;
  logic        rx_bad_block;
  logic        rx_sequence_error;

  logic [73:0] exp_q[$];
  string       name_q[$];
  vec_t        tv[$];
  int          total = 0;
  int          bad   = 0;

  xgmii_baser_dec_64 dut (
    .clk               (clk),
    .rst               (rst),
    .encoded_rx_data   (encoded_rx_data),
    .encoded_rx_hdr    (encoded_rx_hdr),
    .xgmii_rxd         (xgmii_rxd),
    .xgmii_rxc         (xgmii_rxc),
    .rx_bad_block      (rx_bad_block),
    .rx_sequence_error (rx_sequence_error)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_out(input string name, input logic [73:0] e);
    logic [73:0] got;
    got = {xgmii_rxd, xgmii_rxc, rx_bad_block, rx_sequence_error};
    total++;
    if (got !== e) begin
      bad++;
      $display("FAIL %s: got rxd=%h rxc=%h bad=%b seq=%b, want rxd=%h rxc=%h bad=%b seq=%b",
               name, got[73:10], got[9:2], got[1], got[0], e[73:10], e[9:2], e[1], e[0]);
    end
  endtask

  task automatic add(input string name, input logic [1:0] hdr, input logic [63:0] data,
                     input logic [63:0] rxd, input logic [7:0] rxc, input logic b,
                     input logic s);
    vec_t v;
    v.name = name; v.hdr = hdr; v.data = data;
    v.rxd = rxd; v.rxc = rxc; v.bad = b; v.seq = s;
    tv.push_back(v);
  endtask

  // Driver: drive one block, push its expectation, compare after the edge.
  task automatic apply(input vec_t v);
    logic [73:0] e;
    @(negedge clk);
    encoded_rx_hdr  = v.hdr;
    encoded_rx_data = v.data;
    if (v.seq && SEQ_EN) e = {ERR, 8'hFF, 1'b0, 1'b1};
    else                 e = {v.rxd, v.rxc, v.bad, 1'b0};
    exp_q.push_back(e);
    name_q.push_back(v.name);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard: got empty queue, want one entry");
    end else begin
      check_out(name_q.pop_front(), exp_q.pop_front());
    end
  endtask

  initial begin
    vec_t v;
    logic [63:0] rnd;

    add("idle_ctrl",      2'b10, 64'h000000000000001E, IDL,                 8'hFF, 0, 0);
    add("start_s0",       2'b10, 64'hD555555555555578, 64'hD5555555555555FB, 8'h01, 0, 0);
    add("data_in_frame",  2'b01, 64'h1122334455667788, 64'h1122334455667788, 8'h00, 0, 0);
    add("term3",          2'b10, 64'h00000000332211B4, 64'h07070707FD332211, 8'hF8, 0, 0);
    add("bad_hdr00",      2'b00, 64'hDEADBEEF01234567, ERR,                 8'hFF, 1, 0);
    add("data_idle",      2'b01, 64'hA5A5A5A5A5A5A5A5, 64'hA5A5A5A5A5A5A5A5, 8'h00, 0, 1);
    add("ctrl_err_lane2", 2'b10, 64'h000000000780001E, 64'h0707070707FE0707, 8'hFF, 0, 0);
    add("ctrl_ill_lane5", 2'b10, 64'h000008000000001E, ERR,                 8'hFF, 1, 0);
    add("start_c_s4",     2'b10, 64'hCCBBAA0000000033, 64'hCCBBAAFB07070707, 8'h1F, 0, 0);
    add("term0",          2'b10, 64'h0000000000000087, 64'h07070707070707FD, 8'hFF, 0, 0);
    add("start_os",       2'b10, 64'h6655440033221166, 64'h665544FB3322119C, 8'h11, 0, 0);
    add("term7",          2'b10, 64'h07060504030201FF, 64'hFD07060504030201, 8'h80, 0, 0);
    add("term_idle",      2'b10, 64'h0000000000000087, 64'h07070707070707FD, 8'hFF, 0, 1);
    add("os_os",          2'b10, 64'h6655440033221155, 64'h6655449C3322119C, 8'h11, 0, 0);
    add("os_ctrl",        2'b10, 64'h000000003322114B, 64'h070707073322119C, 8'hF1, 0, 0);
    add("os_ctrl_ill",    2'b10, 64'h000000103322114B, ERR,                 8'hFF, 1, 0);
    add("unknown_type",   2'b10, 64'h000000000000002D, ERR,                 8'hFF, 1, 0);
    add("bad_hdr11",      2'b11, 64'h0000000000000078, ERR,                 8'hFF, 1, 0);
    add("start_a",        2'b10, 64'h0102030405060778, 64'h01020304050607FB, 8'h01, 0, 0);
    add("start_in_frame", 2'b10, 64'h1112131415161778, 64'h11121314151617FB, 8'h01, 0, 1);
    add("data_restart",   2'b01, 64'h0F0E0D0C0B0A0908, 64'h0F0E0D0C0B0A0908, 8'h00, 0, 0);
    add("ctrl_in_frame",  2'b10, 64'h000000000000001E, IDL,                 8'hFF, 0, 1);
    add("data_after_ctrl",2'b01, 64'h0000000000000055, 64'h0000000000000055, 8'h00, 0, 1);
    add("start_b",        2'b10, 64'hAABBCCDDEEFF0078, 64'hAABBCCDDEEFF00FB, 8'h01, 0, 0);
    add("bad_over_seq",   2'b10, 64'h000008000000001E, ERR,                 8'hFF, 1, 0);
    add("data_after_bad", 2'b01, 64'h123456789ABCDEF0, 64'h123456789ABCDEF0, 8'h00, 0, 1);

    // Reset: hold, check values during and right after reset.
    rst             = 1'b1;
    encoded_rx_hdr  = 2'b10;
    encoded_rx_data = 64'h000000000000001E;
    repeat (3) @(posedge clk);
    #1;
    check_out("in_reset", {IDL, 8'hFF, 1'b0, 1'b0});
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_out("after_reset", {IDL, 8'hFF, 1'b0, 1'b0});

    for (int i = 0; i < tv.size(); i++) apply(tv[i]);

    // Random data payloads inside a frame pass through untouched.
    v.name = "start_rnd"; v.hdr = 2'b10; v.data = 64'h0000000000000078;
    v.rxd = 64'h00000000000000FB; v.rxc = 8'h01; v.bad = 0; v.seq = 0;
    apply(v);
    for (int i = 0; i < 4; i++) begin
      rnd = {$urandom_range(32'hFFFF_FFFF, 0), $urandom_range(32'hFFFF_FFFF, 0)};
      v.name = "data_rnd"; v.hdr = 2'b01; v.data = rnd;
      v.rxd = rnd; v.rxc = 8'h00; v.bad = 0; v.seq = 0;
      apply(v);
    end

    // Reset in mid-frame discards the frame context.
    v.name = "start_pre_rst"; v.hdr = 2'b10; v.data = 64'h0000000000000078;
    v.rxd = 64'h00000000000000FB; v.rxc = 8'h01; v.bad = 0; v.seq = 0;
    apply(v);
    @(negedge clk);
    encoded_rx_hdr  = 2'b01;
    encoded_rx_data = 64'hCAFEBABECAFEBABE;
    rst = 1'b1;
    #1;
    check_out("async_rst_mid_frame", {IDL, 8'hFF, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    check_out("rst_held", {IDL, 8'hFF, 1'b0, 1'b0});
    @(negedge clk);
    rst = 1'b0;
    v.name = "data_after_rst"; v.hdr = 2'b01; v.data = 64'h0123456789ABCDEF;
    v.rxd = 64'h0123456789ABCDEF; v.rxc = 8'h00; v.bad = 0; v.seq = 1;
    apply(v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
